alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream feeder and result stage for the combinational N-bit ALU (op 00 AND, 01 XOR, 10 ADD, 11 SUB).
//  Accepts {A,B,op} commands over valid/ready and buffers them in a small FIFO.
//  Issues commands one at a time through registered operands into an internal ALU instance.
//  Registers each result and presents it on a valid/ready output, in strict command order.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  DEPTH  4  command FIFO entries; power of two, >=2
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          async reset, active-high
//  in_valid    in   1          command valid
//  in_ready    out  1          command accepted when in_valid&in_ready; = !fifo_full (combinational)
//  in_a        in   WIDTH      operand A
//  in_b        in   WIDTH      operand B
//  in_op       in   2          alu_pkg::op_e
//  out_valid   out  1          result valid; held until out_ready
//  out_ready   in   1          downstream accept
//  out_result  out  WIDTH      registered ALU result
//  out_zero    out  1          result==0              (ALU_FLAGS_EN only)
//  out_carry   out  1          ADD carry-out / SUB borrow (A<B); 0 for AND/XOR  (ALU_FLAGS_EN only)
// BEHAVIOUR
//  Reset: FIFO count/pointers=0, FSM=IDLE, out_valid=0, out_result=0, flags=0.
//   in_ready=1 during and after reset. All queued and in-flight commands are discarded.
//  Arithmetic is modulo 2^WIDTH. Carry/borrow comes from a WIDTH+1-bit sum/difference.
//  FSM:
//   IDLE: if fifo non-empty -> pop head into operand regs -> EXEC.
//   EXEC: capture ALU(op_a,op_b,op) into out_result (+flags); out_valid<=1 -> HOLD.
//   HOLD: out_valid=1; outputs stable while !out_ready.
//    If out_ready and fifo non-empty: pop, go EXEC; out_valid<=0.
//    If out_ready and fifo empty: go IDLE; out_valid<=0.
//  Latency: command accepted at edge E0 -> popped at E1 -> out_valid high after E2 (2 cycles).
//   Peak throughput is one result per 2 cycles.
//  FIFO boundaries:
//   Push into empty FIFO is not visible to the FSM until the next cycle (count is registered).
//   Push and pop in the same cycle: count unchanged; both take effect.
//   Full: in_ready=0; an in_valid held high is ignored until space frees.
//   Pointers wrap modulo DEPTH.
//  Capacity under backpressure: DEPTH queued + 1 in output reg (+1 in operand regs only transiently in EXEC).
//  Reset mid-operation: outputs clear asynchronously; no result from pre-reset commands ever appears.
// CONFIGURATION
//  ALU_FLAGS_EN defined: out_zero/out_carry ports exist, are registered with out_result,
//   and reset to 0.
//  ALU_FLAGS_EN undefined: those ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  alu_pkg: typedef enum logic [1:0] op_e {OP_AND=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11};
//   typedef enum state_e {S_IDLE, S_EXEC, S_HOLD}.
//  Sub-module alu_cmd_fifo (WIDTH*2+2 bits wide, DEPTH entries; push/pop/full/empty).
//  The existing ALU #(WIDTH) is instantiated as the execution unit.
// TESTING
//  1. A=8'h01,B=8'h02,op=00, out_ready=1 -> out_result=8'h00 2 cycles after accept; zero=1, carry=0.
//  2. Same operands, op=01/10/11 in sequence -> 8'h03, 8'h03, 8'hFF (carry=1 borrow), in order.
//  3. ADD 8'hFF+8'h01 -> out_result=8'h00, zero=1, carry=1.
//  4. out_ready=0, offer 6 commands (DEPTH=4) -> 5 accepted then in_ready=0; out_valid/out_result stable;
//     release out_ready -> 5 results in order, in_ready reasserts after first pop.
//  5. 3 commands queued, rst pulsed mid-EXEC -> out_valid=0 immediately, in_ready=1; no stale result after release.
//  6. Continuous in_valid and out_ready=1 with 8 commands -> out_valid high every other cycle, results match golden model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: ALU opcodes and sequencer FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_HOLD = 2'b10
    } state_e;

    localparam int OP_W = 2;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: AND, XOR, ADD, SUB (modulo 2^WIDTH).
// The carry/borrow output exists only when ALU_FLAGS_EN is defined.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry
`endif
);

`ifdef ALU_FLAGS_EN
    // One extra bit gives ADD carry-out and SUB borrow (set when a < b).
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_XOR: result = a ^ b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            default: result = '0;
        endcase
    end
`else
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            default: result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_cmd_fifo.sv
// Command FIFO with a registered occupancy count; head entry is visible on dout
// whenever empty is low. DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: entries are only read after a push marks them live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers {A,B,op} commands, issues them one at a time into the ALU and presents
// registered results in command order. Define ALU_FLAGS_EN to add out_zero/out_carry.
//
//  state  | meaning
//  S_IDLE | no command in flight; pop the FIFO head as soon as one is queued
//  S_EXEC | operands registered; capture the ALU result into the output register
//  S_HOLD | result valid; wait for out_ready, then pop the next command or go idle
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_e              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef ALU_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int CMD_W = 2 * WIDTH + OP_W;

    state_e           state;
    state_e           state_nxt;
    logic             pop;
    logic             load_result;
    logic             clear_valid;

    logic [CMD_W-1:0] fifo_din;
    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    op_e              op_q;
    logic [WIDTH-1:0] alu_result;
`ifdef ALU_FLAGS_EN
    logic             alu_carry;
`endif

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign fifo_din = {in_op, in_a, in_b};

    alu_cmd_fifo #(
        .DW    (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_q),
        .result (alu_result)
`ifdef ALU_FLAGS_EN
        ,
        .carry  (alu_carry)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        load_result = 1'b0;
        clear_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                load_result = 1'b1;
                state_nxt   = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    clear_valid = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            op_q <= OP_AND;
        end else if (pop) begin
            op_q <= op_e'(fifo_dout[CMD_W-1 -: OP_W]);
            op_a <= fifo_dout[2*WIDTH-1 -: WIDTH];
            op_b <= fifo_dout[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef ALU_FLAGS_EN
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
`endif
        end else if (load_result) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
`ifdef ALU_FLAGS_EN
            out_zero   <= (alu_result == '0);
            out_carry  <= alu_carry;
`endif
        end else if (clear_valid) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer (WIDTH=8, DEPTH=4); flag checks
// are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    op_e        in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
`ifdef ALU_FLAGS_EN
    logic       out_zero;
    logic       out_carry;
`endif

    int total;
    int passed;

    alu_cmd_sequencer #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef ALU_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_carry  (out_carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input op_e op);
        logic [8:0] r;
        case (op)
            OP_AND:  r = {1'b0, a & b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            default: r = {1'b0, a} - {1'b0, b};
        endcase
        return r;
    endfunction

    // Single command into an idle sequencer with out_ready=1; checks the exact 2-cycle latency.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input op_e op,
                           input logic [7:0] exp_r, input logic exp_z, input logic exp_c,
                           input string tag);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        chk({tag, "_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, "_v_e0"}, out_valid, 0);
        step();
        chk({tag, "_v_e1"}, out_valid, 0);
        step();
        chk({tag, "_v_e2"}, out_valid, 1);
        chk({tag, "_res"}, out_result, exp_r);
`ifdef ALU_FLAGS_EN
        chk({tag, "_zero"}, out_zero, exp_z);
        chk({tag, "_carry"}, out_carry, exp_c);
`else
        if (exp_z === 1'bx || exp_c === 1'bx) $display("note: unknown flag expectation in %s", tag);
`endif
        step();
        chk({tag, "_v_e3"}, out_valid, 0);
    endtask

    logic [7:0] t6_a  [8];
    logic [7:0] t6_b  [8];
    op_e        t6_op [8];

    initial begin
        int stale;
        int sidx;
        int ridx;
        int last;
        logic acc;
        logic [8:0] m;

        total = 0; passed = 0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_AND; out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
`ifdef ALU_FLAGS_EN
        chk("rst_zero", out_zero, 0);
        chk("rst_carry", out_carry, 0);
`endif
        step(); step();
        rst = 1'b0;
        step();

        // Single operations, one op after another
        run_one(8'h01, 8'h02, OP_AND, 8'h00, 1'b1, 1'b0, "t1_and");
        run_one(8'h01, 8'h02, OP_XOR, 8'h03, 1'b0, 1'b0, "t2_xor");
        run_one(8'h01, 8'h02, OP_ADD, 8'h03, 1'b0, 1'b0, "t2_add");
        run_one(8'h01, 8'h02, OP_SUB, 8'hFF, 1'b0, 1'b1, "t2_sub");
        run_one(8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, "t3_wrap");

        // Backpressure: 5 commands fit (4 queued + 1 in output reg), 6th is held off
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_a = 8'(k + 1); in_b = 8'h10; in_op = OP_ADD; in_valid = 1'b1;
            chk($sformatf("t4_ready_%0d", k), in_ready, 1);
            step();
        end
        in_a = 8'h06; in_b = 8'h10; in_op = OP_ADD; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_full_%0d", k), in_ready, 0);
            chk($sformatf("t4_hold_v_%0d", k), out_valid, 1);
            chk($sformatf("t4_hold_r_%0d", k), out_result, 8'h11);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t4_ready_after_pop", in_ready, 1);
        chk("t4_v_after_pop", out_valid, 0);
        ridx = 1;
        for (int cyc = 0; cyc < 20 && ridx < 5; cyc++) begin
            if (out_valid) begin
                chk($sformatf("t4_res_%0d", ridx), out_result, 8'(8'h11 + ridx));
                ridx++;
            end
            step();
        end
        chk("t4_count", ridx, 5);
        stale = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (out_valid) stale++;
            step();
        end
        chk("t4_no_extra", stale, 0);

        // Reset while a command is in EXEC with more queued
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h20; in_b = 8'h01; in_op = OP_ADD; step();
        in_a = 8'h0F; in_b = 8'hF0; in_op = OP_XOR; step();
        in_a = 8'h3C; in_b = 8'h0F; in_op = OP_AND; step();
        in_valid = 1'b0;
        chk("t5_first_v", out_valid, 1);
        chk("t5_first_r", out_result, 8'h21);
        out_ready = 1'b1;
        step();
        chk("t5_exec_v", out_valid, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_v", out_valid, 0);
        chk("t5_rst_r", out_result, 0);
        chk("t5_rst_ready", in_ready, 1);
        step();
        rst = 1'b0;
        stale = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) stale++;
            step();
        end
        chk("t5_no_stale", stale, 0);
        run_one(8'h0A, 8'h03, OP_SUB, 8'h07, 1'b0, 1'b0, "t5_recover");

        // Streaming: continuous input, out_ready=1, one result every other cycle
        t6_a  = '{8'h10, 8'hF0, 8'h55, 8'h00, 8'h80, 8'h7F, 8'h33, 8'h01};
        t6_b  = '{8'h0F, 8'h20, 8'hAA, 8'h01, 8'h80, 8'h7F, 8'h33, 8'hFF};
        t6_op = '{OP_AND, OP_ADD, OP_XOR, OP_SUB, OP_ADD, OP_SUB, OP_XOR, OP_ADD};
        sidx = 0; ridx = 0; last = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && ridx < 8; cyc++) begin
            if (out_valid) begin
                m = model(t6_a[ridx], t6_b[ridx], t6_op[ridx]);
                chk($sformatf("t6_res_%0d", ridx), out_result, m[7:0]);
`ifdef ALU_FLAGS_EN
                chk($sformatf("t6_zero_%0d", ridx), out_zero, (m[7:0] == 8'h00));
                chk($sformatf("t6_carry_%0d", ridx), out_carry, m[8]);
`endif
                if (ridx > 0) chk($sformatf("t6_gap_%0d", ridx), cyc - last, 2);
                last = cyc;
                ridx++;
            end
            if (sidx < 8) begin
                in_a = t6_a[sidx]; in_b = t6_b[sidx]; in_op = t6_op[sidx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) sidx++;
        end
        in_valid = 1'b0;
        chk("t6_count", ridx, 8);
        chk("t6_sent", sidx, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
